// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, index constants and word/index types for the register file
package rf_pkg;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port: index-0 zeroing and optional write-through bypass
// Bypass compare/mux is present only when REGFILE_BYPASS_EN is defined.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic [AW-1:0] i_rd_addr,
    input  logic [DW-1:0] i_rd_word,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic [DW-1:0] o_rd_data
);
    logic w_is_zero;
    assign w_is_zero = (i_rd_addr == AW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    // i_wr_en already excludes reset and index 0, so a hit never leaks a discarded write
    assign w_hit = i_wr_en && (i_wr_addr == i_rd_addr);

    always_comb begin
        o_rd_data = i_rd_word;
        if (w_is_zero) begin
            o_rd_data = '0;
        end else if (w_hit) begin
            o_rd_data = i_wr_data;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{1'b0, i_wr_en, i_wr_addr, i_wr_data};

    always_comb begin
        o_rd_data = i_rd_word;
        if (w_is_zero) begin
            o_rd_data = '0;
        end
    end
`endif
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two read ports, one write port, debug read and retired-write counter
// Optional same-cycle write-through bypass on the read ports under REGFILE_BYPASS_EN.
module reg_file
    import rf_pkg::*;
#(
    parameter int DW    = rf_pkg::DW,
    parameter int AW    = rf_pkg::AW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite,
    input  logic [AW-1:0]    WrAddr,
    input  logic [DW-1:0]    WrData,
    input  logic [AW-1:0]    RdAddr1,
    input  logic [AW-1:0]    RdAddr2,
    output logic [DW-1:0]    RdData1,
    output logic [DW-1:0]    RdData2,
    input  logic [AW-1:0]    DbgAddr,
    output logic [DW-1:0]    DbgData,
    output logic [CNT_W-1:0] WrCount
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    r_regs [DEPTH];
    logic [CNT_W-1:0] r_wr_count;
    logic             w_wr_commit;
    logic             w_bypass_en;

    assign w_wr_commit = RegWrite && (WrAddr != AW'(REG_ZERO));
    assign w_bypass_en = w_wr_commit && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wr_commit) begin
            r_regs[WrAddr] <= WrData;
            r_wr_count     <= r_wr_count + 1'b1;
        end
    end

    rf_read_port #(.DW(DW), .AW(AW)) u_rd_port1 (
        .i_rd_addr (RdAddr1),
        .i_rd_word (r_regs[RdAddr1]),
        .i_wr_en   (w_bypass_en),
        .i_wr_addr (WrAddr),
        .i_wr_data (WrData),
        .o_rd_data (RdData1)
    );

    rf_read_port #(.DW(DW), .AW(AW)) u_rd_port2 (
        .i_rd_addr (RdAddr2),
        .i_rd_word (r_regs[RdAddr2]),
        .i_wr_en   (w_bypass_en),
        .i_wr_addr (WrAddr),
        .i_wr_data (WrData),
        .o_rd_data (RdData2)
    );

    // Debug view is always the stored contents, never the bypassed value
    assign DbgData = (DbgAddr == AW'(REG_ZERO)) ? '0 : r_regs[DbgAddr];
    assign WrCount = r_wr_count;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file (counter narrowed to 4 bits to reach the wrap)
module tb_reg_file;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    localparam int K_RD1 = 0;
    localparam int K_RD2 = 1;
    localparam int K_DBG = 2;
    localparam int K_CNT = 3;

    logic             clk;
    logic             rst;
    logic             RegWrite;
    logic [AW-1:0]    WrAddr;
    logic [DW-1:0]    WrData;
    logic [AW-1:0]    RdAddr1;
    logic [AW-1:0]    RdAddr2;
    logic [DW-1:0]    RdData1;
    logic [DW-1:0]    RdData2;
    logic [AW-1:0]    DbgAddr;
    logic [DW-1:0]    DbgData;
    logic [CNT_W-1:0] WrCount;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        int          id;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  next_id  = 0;

    reg_file #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .RegWrite (RegWrite),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .RdAddr1  (RdAddr1),
        .RdAddr2  (RdAddr2),
        .RdData1  (RdData1),
        .RdData2  (RdData2),
        .DbgAddr  (DbgAddr),
        .DbgData  (DbgData),
        .WrCount  (WrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input int kind, input logic [31:0] exp);
        sb_t e;
        e.kind = kind;
        e.exp  = exp;
        e.id   = next_id;
        next_id++;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        RegWrite = 1'b1;
        WrAddr   = a;
        WrData   = d;
        cyc();
        RegWrite = 1'b0;
    endtask

    // Monitor: outputs are combinational, so the DUT presents them every cycle; sample mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            sb_t         e;
            logic [31:0] act;
            string       nm;
            e = sb_q.pop_front();
            case (e.kind)
                K_RD1:   begin act = RdData1;             nm = "RdData1"; end
                K_RD2:   begin act = RdData2;             nm = "RdData2"; end
                K_DBG:   begin act = DbgData;             nm = "DbgData"; end
                default: begin act = {28'b0, WrCount};    nm = "WrCount"; end
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL chk%0d %s: got 0x%08h, required 0x%08h", e.id, nm, act, e.exp);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        RegWrite = 1'b0;
        WrAddr   = '0;
        WrData   = '0;
        RdAddr1  = '0;
        RdAddr2  = '0;
        DbgAddr  = '0;
        cyc();
        rst = 1'b0;

        // Reset clears a preloaded register and the counter
        wr(5'd5, 32'hDEADBEEF);
        RdAddr1 = 5'd5;
        expect_out(K_RD1, 32'hDEADBEEF);
        expect_out(K_CNT, 32'd1);
        rst = 1'b1;
        cyc();
        rst     = 1'b0;
        RdAddr2 = 5'd31;
        DbgAddr = 5'd5;
        expect_out(K_RD1, 32'h0);
        expect_out(K_RD2, 32'h0);
        expect_out(K_DBG, 32'h0);
        expect_out(K_CNT, 32'd0);
        cyc();

        // Basic write, visible next cycle
        wr(5'd8, 32'h12345678);
        RdAddr2 = 5'd8;
        expect_out(K_RD2, 32'h12345678);
        expect_out(K_CNT, 32'd1);
        cyc();

        // Writes to index 0 are discarded and not counted
        wr(5'd0, 32'hFFFFFFFF);
        RdAddr1 = 5'd0;
        DbgAddr = 5'd0;
        expect_out(K_RD1, 32'h0);
        expect_out(K_DBG, 32'h0);
        expect_out(K_CNT, 32'd1);
        cyc();

        // Same-cycle read of the register being written
        wr(5'd9, 32'h00000001);
        RegWrite = 1'b1;
        WrAddr   = 5'd9;
        WrData   = 32'hA5A5A5A5;
        RdAddr1  = 5'd9;
        RdAddr2  = 5'd9;
        DbgAddr  = 5'd9;
`ifdef REGFILE_BYPASS_EN
        expect_out(K_RD1, 32'hA5A5A5A5);
        expect_out(K_RD2, 32'hA5A5A5A5);
`else
        expect_out(K_RD1, 32'h00000001);
        expect_out(K_RD2, 32'h00000001);
`endif
        expect_out(K_DBG, 32'h00000001);
        expect_out(K_CNT, 32'd2);
        cyc();
        RegWrite = 1'b0;
        expect_out(K_RD1, 32'hA5A5A5A5);
        expect_out(K_RD2, 32'hA5A5A5A5);
        expect_out(K_CNT, 32'd3);
        cyc();

        // Reset wins over a write in the same cycle
        rst      = 1'b1;
        RegWrite = 1'b1;
        WrAddr   = 5'd3;
        WrData   = 32'd7;
        cyc();
        rst      = 1'b0;
        RegWrite = 1'b0;
        RdAddr1  = 5'd3;
        RdAddr2  = 5'd9;
        DbgAddr  = 5'd3;
        expect_out(K_RD1, 32'h0);
        expect_out(K_RD2, 32'h0);
        expect_out(K_DBG, 32'h0);
        expect_out(K_CNT, 32'd0);
        cyc();

        // Two distinct registers read on both ports, then RegWrite=0 leaves state alone
        wr(5'd31, 32'h80000001);
        wr(5'd2, 32'h0F0F0F0F);
        RdAddr1  = 5'd31;
        RdAddr2  = 5'd2;
        WrAddr   = 5'd31;
        WrData   = 32'h55555555;
        cyc();
        expect_out(K_RD1, 32'h80000001);
        expect_out(K_RD2, 32'h0F0F0F0F);
        expect_out(K_CNT, 32'd2);
        cyc();

        // Counter wrap: 17 writes to r1 with a 4-bit counter
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr(5'd1, 32'd100 + 32'(i));
        end
        DbgAddr = 5'd1;
        RdAddr1 = 5'd1;
        expect_out(K_CNT, 32'd1);
        expect_out(K_DBG, 32'd116);
        expect_out(K_RD1, 32'd116);
        cyc();

        cyc();
        cyc();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
